// File: rtl/vga_pkg.sv
// Shared VGA/VRAM constants, arbiter state encoding and the write-FIFO entry layout.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int PIX_W    = 12;
  localparam int VADDR_W  = 19;
  localparam int ROW_W    = 9;
  localparam int COL_W    = 10;

  // Last visible row/column, sized to the coordinate buses.
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(V_ACTIVE - 1);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(H_ACTIVE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  // One pending pixel write as held in the write FIFO.
  typedef struct packed {
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic [PIX_W-1:0] data;
  } wr_ent_t;

  // True when (row, col) lies inside the visible frame.
  function automatic logic in_frame(input logic [ROW_W-1:0] row,
                                    input logic [COL_W-1:0] col);
    return (row <= ROW_MAX) && (col <= COL_MAX);
  endfunction

endpackage

// File: rtl/vram_arbiter_if.sv
// Bundle of scanout, pixel-writer and VRAM signals around the arbiter.
// Latency: n/a (wiring only).
// Backpressure: writer side is valid/ready; scanout and VRAM sides have none.
// Ports: scan_rd/scan_row/scan_col -> scan_pix; wr_valid/wr_row/wr_col/wr_data <-> wr_ready;
//        mem_addr/mem_we/mem_wdata -> VRAM, mem_rdata <- VRAM; stall_cnt statistic.
interface vram_arbiter_if;
  import vga_pkg::*;

  logic               scan_rd;
  logic [ROW_W-1:0]   scan_row;
  logic [COL_W-1:0]   scan_col;
  logic [PIX_W-1:0]   scan_pix;

  logic               wr_valid;
  logic               wr_ready;
  logic [ROW_W-1:0]   wr_row;
  logic [COL_W-1:0]   wr_col;
  logic [PIX_W-1:0]   wr_data;

  logic [VADDR_W-1:0] mem_addr;
  logic               mem_we;
  logic [PIX_W-1:0]   mem_wdata;
  logic [PIX_W-1:0]   mem_rdata;

  logic [15:0]        stall_cnt;

  // master: the arbiter itself (serves the scanout/writer, drives the VRAM).
  modport master (
    input  scan_rd, scan_row, scan_col, wr_valid, wr_row, wr_col, wr_data, mem_rdata,
    output scan_pix, wr_ready, mem_addr, mem_we, mem_wdata, stall_cnt
  );

  // slave: the surroundings (scanout, pixel writer and the VRAM macro).
  modport slave (
    output scan_rd, scan_row, scan_col, wr_valid, wr_row, wr_col, wr_data, mem_rdata,
    input  scan_pix, wr_ready, mem_addr, mem_we, mem_wdata, stall_cnt
  );
endinterface

// File: rtl/vram_wr_fifo.sv
// Small circular FIFO holding pixel writes until a free VRAM cycle.
// Latency: a push is visible at the head on the next cycle; head is read combinationally.
// Backpressure: push ignored when full, pop ignored when empty; full/count are registered.
// Ports: vga_clk, rst (async active-low), push/push_dat, pop/head_dat, full, empty, count.
module vram_wr_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 31
) (
  input  logic                   vga_clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           push_dat,
  input  logic                   pop,
  output logic [W-1:0]           head_dat,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          do_push;
  logic          do_pop;

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign head_dat = mem[rptr];

  // DEPTH is a power of two, so the pointers wrap on natural overflow.
  always_ff @(posedge vga_clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge vga_clk) begin
    if (do_push) mem[wptr] <= push_dat;
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: scanout reads always win, buffered pixel writes fill idle cycles.
// Latency: one VRAM access per cycle; scan_pix returns the pixel 1 cycle after the read.
// Backpressure: wr_ready drops while the write FIFO is full; scanout is never held off.
// Ports: vga_clk, rst (async active-low), bus (vram_arbiter_if.master).
// Optional VRAM_ARBITER_STATS_EN: stall_cnt counts cycles with wr_valid=1 and wr_ready=0
// (saturating); without it stall_cnt is tied to 0.
module vram_arbiter
  import vga_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic           vga_clk,
  input  logic           rst,
  vram_arbiter_if.master bus
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  arb_state_t       state;
  arb_state_t       state_q;
  wr_ent_t          push_ent;
  wr_ent_t          head_ent;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  // Readiness depends only on the registered occupancy, so a pop in the
  // same cycle never opens a slot for a push when full.
  assign bus.wr_ready = (fifo_count < CNT_W'(FIFO_DEPTH));

  // Off-screen writes are accepted from the writer but dropped here.
  assign push     = bus.wr_valid && !fifo_full && in_frame(bus.wr_row, bus.wr_col);
  assign push_ent = '{row: bus.wr_row, col: bus.wr_col, data: bus.wr_data};

  vram_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     ($bits(wr_ent_t))
  ) u_fifo (
    .vga_clk  (vga_clk),
    .rst      (rst),
    .push     (push),
    .push_dat (push_ent),
    .pop      (pop),
    .head_dat (head_ent),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  // The access type is chosen fresh every cycle so the scanout read is issued
  // in the very cycle it is requested; state_q remembers last cycle's choice.
  always_ff @(posedge vga_clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state;
  end

  always_comb begin
    state         = IDLE;
    pop           = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    if (!rst)              state = IDLE;
    else if (bus.scan_rd)  state = SCAN;
    else if (!fifo_empty)  state = DRAIN;
    case (state)
      SCAN: begin
        bus.mem_addr = {bus.scan_row, bus.scan_col};
      end
      DRAIN: begin
        bus.mem_addr  = {head_ent.row, head_ent.col};
        bus.mem_we    = 1'b1;
        bus.mem_wdata = head_ent.data;
        pop           = 1'b1;
      end
      default: ;
    endcase
  end

  // VRAM read data already arrives one cycle after the address, so the
  // registered qualifier (last cycle was SCAN) selects it straight through;
  // any other cycle shows black.
  assign bus.scan_pix = (state_q == SCAN) ? bus.mem_rdata : '0;

`ifdef VRAM_ARBITER_STATS_EN
  logic [15:0] stall_q;

  always_ff @(posedge vga_clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
    end else if (bus.wr_valid && !bus.wr_ready && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign bus.stall_cnt = stall_q;
`else
  assign bus.stall_cnt = '0;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboarded randomized bench for vram_arbiter with an abstract pending-write model.
// Latency: n/a.
// Backpressure: writer honours wr_ready as predicted by the model.
module tb_vram_arbiter;
  import vga_pkg::*;

  localparam int DEPTH = 4;

  typedef struct {
    logic [18:0] addr;
    logic [11:0] data;
  } wr_t;

  typedef struct {
    bit          rstc;
    bit          rdy;
    bit          we;
    bit          scan;
    logic [18:0] addr;
    logic [11:0] wdata;
    logic [11:0] pix;
    logic [15:0] stall;
  } exp_t;

  logic vga_clk = 1'b0;
  logic rst     = 1'b0;

  vram_arbiter_if bus ();

  vram_arbiter #(.FIFO_DEPTH(DEPTH)) dut (
    .vga_clk (vga_clk),
    .rst     (rst),
    .bus     (bus)
  );

  always #5 vga_clk = ~vga_clk;

  // VRAM stand-in: synchronous read returning the low address bits.
  always @(posedge vga_clk) bus.mem_rdata <= bus.mem_addr[11:0];

  int tests = 0;
  int fails = 0;

  wr_t         model_q[$];
  exp_t        exp_q[$];
  bit          prev_scan = 1'b0;
  logic [11:0] prev_pix  = '0;
  logic [15:0] stall_m   = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // One clock cycle: drive inputs, predict the cycle's outputs, advance.
  task automatic step(input bit r, input bit s, input logic [8:0] sr, input logic [9:0] sc,
                      input bit wv, input logic [8:0] wr, input logic [9:0] wc,
                      input logic [11:0] wd, output bit acc);
    exp_t        e;
    wr_t         ent;
    logic [18:0] sa;
    rst          = r;
    bus.scan_rd  = s;
    bus.scan_row = sr;
    bus.scan_col = sc;
    bus.wr_valid = wv;
    bus.wr_row   = wr;
    bus.wr_col   = wc;
    bus.wr_data  = wd;
    e = '{rstc: 1'b0, rdy: 1'b1, we: 1'b0, scan: 1'b0, addr: '0, wdata: '0, pix: '0, stall: '0};
    acc = 1'b0;
    if (!r) begin
      e.rstc = 1'b1;
      model_q.delete();
      prev_scan = 1'b0;
      stall_m   = '0;
    end else begin
      e.rdy   = (model_q.size() < DEPTH);
      e.pix   = prev_scan ? prev_pix : 12'h000;
      e.stall = stall_m;
      e.scan  = s;
      sa      = {sr, sc};
      if (s) begin
        e.addr = sa;
      end else if (model_q.size() > 0) begin
        ent     = model_q.pop_front();
        e.we    = 1'b1;
        e.addr  = ent.addr;
        e.wdata = ent.data;
      end
      acc = wv && e.rdy;
      if (acc && (wr < 9'd480) && (wc < 10'd640)) model_q.push_back('{addr: {wr, wc}, data: wd});
`ifdef VRAM_ARBITER_STATS_EN
      if (wv && !e.rdy && (stall_m != 16'hFFFF)) stall_m = stall_m + 16'd1;
`endif
      prev_scan = s;
      prev_pix  = sa[11:0];
    end
    exp_q.push_back(e);
    @(posedge vga_clk);
    #1;
  endtask

  // Monitor: compares each cycle's outputs against the queued prediction.
  always @(negedge vga_clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("wr_ready", 32'(bus.wr_ready), 32'(e.rdy));
      chk("mem_we", 32'(bus.mem_we), 32'(e.we));
      if (e.we || e.scan || e.rstc) chk("mem_addr", 32'(bus.mem_addr), 32'(e.addr));
      if (e.we || e.rstc) chk("mem_wdata", 32'(bus.mem_wdata), 32'(e.wdata));
      chk("scan_pix", 32'(bus.scan_pix), 32'(e.pix));
      chk("stall_cnt", 32'(bus.stall_cnt), 32'(e.stall));
    end
  end

  initial begin
    bit          acc;
    wr_t         wq[$];
    int          k;
    bit          s;
    int          burst;
    logic [8:0]  wr;
    logic [9:0]  wc;

    @(posedge vga_clk);
    #1;
    // Reset state.
    repeat (2) step(0, 1, 9'd5, 10'd7, 1, 9'd1, 10'd1, 12'hABC, acc);

    // Three writes queued behind scanout, then drained back-to-back.
    step(1, 1, 9'd0, 10'd100, 1, 9'd0,   10'd0,   12'h0F0, acc);
    step(1, 1, 9'd0, 10'd101, 1, 9'd0,   10'd1,   12'h00F, acc);
    step(1, 1, 9'd0, 10'd102, 1, 9'd479, 10'd639, 12'hFFF, acc);
    repeat (5) step(1, 0, 9'd0, 10'd0, 0, 9'd0, 10'd0, 12'h000, acc);

    // A full scanline with DEPTH+2 writes pending.
    wq.delete();
    for (int i = 0; i < DEPTH + 2; i++)
      wq.push_back('{addr: {9'(i * 7), 10'(i * 13)}, data: 12'(16'h100 + i)});
    k = 0;
    for (int c = 0; c < 640 + 12; c++) begin
      s = (c < 640);
      if (k < wq.size())
        step(1, s, 9'd37, 10'(c % 640), 1, wq[k].addr[18:10], wq[k].addr[9:0], wq[k].data, acc);
      else
        step(1, s, 9'd37, 10'(c % 640), 0, 9'd0, 10'd0, 12'h000, acc);
      if (acc) k++;
    end

    // Off-screen writes are swallowed.
    step(1, 0, 9'd0, 10'd0, 1, 9'd480, 10'd0,   12'h123, acc);
    step(1, 0, 9'd0, 10'd0, 1, 9'd0,   10'd640, 12'h456, acc);
    step(1, 0, 9'd0, 10'd0, 0, 9'd0,   10'd0,   12'h000, acc);
    chk("count_after_oob", 32'(dut.fifo_count), 32'd0);
    repeat (2) step(1, 0, 9'd0, 10'd0, 0, 9'd0, 10'd0, 12'h000, acc);

    // Reset with three entries pending.
    for (int i = 0; i < 3; i++)
      step(1, 1, 9'd9, 10'(i), 1, 9'(i + 1), 10'(i + 2), 12'(i + 12'h700), acc);
    step(0, 1, 9'd9, 10'd3, 0, 9'd0, 10'd0, 12'h000, acc);
    chk("count_after_rst", 32'(dut.fifo_count), 32'd0);
    repeat (6) step(1, 0, 9'd0, 10'd0, 0, 9'd0, 10'd0, 12'h000, acc);

    // Randomized traffic with bursty scanout.
    burst = 0;
    s = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if (burst == 0) begin
        s = ~s;
        burst = s ? int'($urandom_range(1, 40)) : int'($urandom_range(0, 8));
      end else begin
        burst--;
      end
      if ($urandom_range(0, 7) == 0) begin
        wr = 9'($urandom_range(0, 511));
        wc = 10'($urandom_range(0, 1023));
      end else begin
        wr = 9'($urandom_range(0, 479));
        wc = 10'($urandom_range(0, 639));
      end
      step(($urandom_range(0, 299) != 0), s, 9'($urandom_range(0, 479)), 10'($urandom_range(0, 639)),
           ($urandom_range(0, 9) < 6), wr, wc, 12'($urandom), acc);
    end
    repeat (8) step(1, 0, 9'd0, 10'd0, 0, 9'd0, 10'd0, 12'h000, acc);

`ifdef VRAM_ARBITER_STATS_EN
    // Stall counting and saturation.
    step(0, 0, 9'd0, 10'd0, 0, 9'd0, 10'd0, 12'h000, acc);
    for (int i = 0; i < DEPTH; i++)
      step(1, 1, 9'd2, 10'(i), 1, 9'd3, 10'(i), 12'h321, acc);
    repeat (10) step(1, 1, 9'd2, 10'd50, 1, 9'd3, 10'd9, 12'h321, acc);
    chk("stall_10", 32'(bus.stall_cnt), 32'd10);
    for (int i = 0; i < 65530; i++)
      step(1, 1, 9'd2, 10'(i % 640), 1, 9'd3, 10'd9, 12'h321, acc);
    chk("stall_sat", 32'(bus.stall_cnt), 32'hFFFF);
    repeat (8) step(1, 0, 9'd0, 10'd0, 0, 9'd0, 10'd0, 12'h000, acc);
`endif

    #10;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
